// File: rtl/move_queue.sv
// Keyboard-to-direction front end: decodes scan codes into moves, queues up to
// DEPTH accepted turns and releases one per game step, with a pause toggle.
module move_queue #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] KEY_RIGHT = 8'h74,
  parameter logic [7:0] KEY_UP    = 8'h75,
  parameter logic [7:0] KEY_LEFT  = 8'h6B,
  parameter logic [7:0] KEY_DOWN  = 8'h72,
  parameter logic [7:0] KEY_PAUSE = 8'h29,
  parameter logic [1:0] INIT_MOVE = 2'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       newKey,
  input  logic [7:0]                 keyCode,
  input  logic                       step,
  output logic [1:0]                 move,
  output logic                       paused,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [1:0]       queue [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tail_ptr;

  logic       key_is_dir;
  logic [1:0] key_dir;
  logic       key_pause;
  logic [1:0] last;
  logic       empty;
  logic       full;
  logic       dir_ok;
  logic       push;
  logic       pop;
  logic       drop;

  always_comb begin
    key_is_dir = 1'b0;
    key_dir    = 2'd0;
    if (newKey) begin
      if (keyCode == KEY_RIGHT) begin
        key_is_dir = 1'b1;
        key_dir    = 2'd0;
      end else if (keyCode == KEY_UP) begin
        key_is_dir = 1'b1;
        key_dir    = 2'd1;
      end else if (keyCode == KEY_LEFT) begin
        key_is_dir = 1'b1;
        key_dir    = 2'd2;
      end else if (keyCode == KEY_DOWN) begin
        key_is_dir = 1'b1;
        key_dir    = 2'd3;
      end
    end
  end

  assign key_pause = newKey && (keyCode == KEY_PAUSE);
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign tail_ptr  = wr_ptr - 1'b1;

  // Reversal/duplicate checks are against the newest queued turn, not the current move.
  assign last   = empty ? move : queue[tail_ptr];
  assign dir_ok = key_is_dir && !paused && (key_dir != last) && (key_dir != (last ^ 2'd2));
  assign pop    = step && !paused && !empty;
  assign push   = dir_ok && (!full || pop);
  assign drop   = dir_ok && full && !pop;

  always_ff @(posedge clk) begin
    if (push) queue[wr_ptr] <= key_dir;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      move     <= INIT_MOVE;
      paused   <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      overflow <= drop;
      if (key_pause) paused <= ~paused;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        move   <= queue[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
